// File: rtl/wb_arb_pkg.sv
// Shared types for the regfile writeback arbiter.
// Address/data widths and the buffered result entry.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order buffer for MDU results awaiting a free write slot.
// Extra pointer MSB separates full from empty.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      start,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance; wraps modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port: writeback first, MDU results drained.
// WB_SCOREBOARD_EN adds a pending-register scoreboard driving stall.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  start,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0]     mdu_data,
  input  logic                  mdu_issue,
  input  logic [REG_ADDR_W-1:0] mdu_issue_addr,
  input  logic [REG_ADDR_W-1:0] ReadRegister1,
  input  logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic                  stall,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0]     WriteData
);

  logic      wb_take;
  logic      push;
  logic      pop;
  logic      full;
  logic      empty;
  wb_entry_t head;
  wb_entry_t in_ent;

  assign wb_take   = wb_valid && (wb_addr != '0);
  assign mdu_ready = !full;
  assign push      = mdu_valid && mdu_ready && (mdu_addr != '0);
  assign pop       = !wb_take && !empty;
  assign in_ent    = '{addr: mdu_addr, data: mdu_data};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .start     (start),
    .push      (push),
    .push_data (in_ent),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // Registered write port: wb wins, else drain buffer head.
  always_ff @(posedge clk) begin
    if (start) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (wb_take) begin
      RegWrite      <= 1'b1;
      WriteRegister <= wb_addr;
      WriteData     <= wb_data;
    end else if (pop) begin
      RegWrite      <= 1'b1;
      WriteRegister <= head.addr;
      WriteData     <= head.data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending;
  logic        raw1;
  logic        raw2;
  logic        waw;

  // Pending bits: clear on pop to regfile, set on issue (set wins).
  always_ff @(posedge clk) begin
    if (start) begin
      pending <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (mdu_issue && mdu_issue_addr == REG_ADDR_W'(i))
          pending[i] <= 1'b1;
        else if (pop && head.addr == REG_ADDR_W'(i))
          pending[i] <= 1'b0;
      end
      pending[0] <= 1'b0;
    end
  end

  assign raw1 = (ReadRegister1 != '0) && pending[ReadRegister1];
  assign raw2 = (ReadRegister2 != '0) && pending[ReadRegister2];
  assign waw  = mdu_issue && (mdu_issue_addr != '0) &&
                pending[mdu_issue_addr];

  assign stall = full || raw1 || raw2 || waw;
`else
  logic unused_sb;
  assign unused_sb = ^{mdu_issue, mdu_issue_addr,
                       ReadRegister1, ReadRegister2};
  assign stall = full;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2).
// Vector table plus hand-written multi-cycle sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        start;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_addr;
  logic [4:0]  rr1;
  logic [4:0]  rr2;
  logic        stall;
  logic        rw;
  logic [4:0]  wr;
  logic [31:0] wd;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk            (clk),
    .start          (start),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .mdu_valid      (mdu_valid),
    .mdu_ready      (mdu_ready),
    .mdu_addr       (mdu_addr),
    .mdu_data       (mdu_data),
    .mdu_issue      (mdu_issue),
    .mdu_issue_addr (mdu_issue_addr),
    .ReadRegister1  (rr1),
    .ReadRegister2  (rr2),
    .stall          (stall),
    .RegWrite       (rw),
    .WriteRegister  (wr),
    .WriteData      (wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wdat;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_st;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
    mdu_issue = 0; mdu_issue_addr = 0;
    rr1 = 0; rr2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic e_rw,
                         input logic [4:0] e_wr,
                         input logic [31:0] e_wd,
                         input logic e_rdy, input logic e_st);
    chk({nm, ".RegWrite"}, 32'(rw), 32'(e_rw));
    if (e_rw) begin
      chk({nm, ".WriteRegister"}, 32'(wr), 32'(e_wr));
      chk({nm, ".WriteData"}, wd, e_wd);
    end
    chk({nm, ".mdu_ready"}, 32'(mdu_ready), 32'(e_rdy));
    chk({nm, ".stall"}, 32'(stall), 32'(e_st));
  endtask

  task automatic do_reset();
    start = 1;
    for (int i = 0; i < 2; i++) begin
      wb_valid  = 1'($urandom);
      wb_addr   = 5'($urandom);
      wb_data   = $urandom;
      mdu_valid = 1'($urandom);
      mdu_addr  = 5'($urandom);
      mdu_data  = $urandom;
      tick();
    end
    start = 0;
    idle_in();
  endtask

  initial begin
    idle_in();
    start = 1;

    // name, wv,wa,wd, mv,ma,md, rw,wr,wd, rdy,stall
    vecs.push_back('{"wb5", 1,5,32'hDEADBEEF, 0,0,0,
                     1,5,32'hDEADBEEF, 1,0});
    vecs.push_back('{"wb5_off", 0,0,0, 0,0,0,
                     0,5,32'hDEADBEEF, 1,0});
    vecs.push_back('{"coll_wb", 1,3,32'h11, 1,7,32'h22,
                     1,3,32'h11, 1,0});
    vecs.push_back('{"coll_mdu", 0,0,0, 0,0,0,
                     1,7,32'h22, 1,0});
    vecs.push_back('{"coll_off", 0,0,0, 0,0,0,
                     0,7,32'h22, 1,0});
    vecs.push_back('{"r0_a", 1,0,32'h55, 1,0,32'h66,
                     0,7,32'h22, 1,0});
    vecs.push_back('{"r0_b", 1,0,32'h57, 1,0,32'h68,
                     0,7,32'h22, 1,0});
    vecs.push_back('{"r0_c", 0,0,0, 0,0,0,
                     0,7,32'h22, 1,0});
    vecs.push_back('{"r0wb_push", 1,0,32'h44, 1,12,32'h33,
                     0,7,32'h22, 1,0});
    vecs.push_back('{"r0wb_pop", 1,0,32'h77, 0,0,0,
                     1,12,32'h33, 1,0});
    vecs.push_back('{"r0wb_off", 0,0,0, 0,0,0,
                     0,12,32'h33, 1,0});
    vecs.push_back('{"wb31", 1,31,32'hFFFFFFFF, 0,0,0,
                     1,31,32'hFFFFFFFF, 1,0});
    vecs.push_back('{"wb31_off", 0,0,0, 0,0,0,
                     0,31,32'hFFFFFFFF, 1,0});

    do_reset();
    chk("rst.RegWrite", 32'(rw), 0);
    chk("rst.WriteRegister", 32'(wr), 0);
    chk("rst.WriteData", wd, 0);
    chk("rst.mdu_ready", 32'(mdu_ready), 1);
    chk("rst.stall", 32'(stall), 0);

    foreach (vecs[i]) begin
      wb_valid  = vecs[i].wv;
      wb_addr   = vecs[i].wa;
      wb_data   = vecs[i].wdat;
      mdu_valid = vecs[i].mv;
      mdu_addr  = vecs[i].ma;
      mdu_data  = vecs[i].md;
      tick();
      chk_out(vecs[i].name, vecs[i].e_rw, vecs[i].e_wr,
              vecs[i].e_wd, vecs[i].e_rdy, vecs[i].e_st);
      chk({vecs[i].name, ".WriteRegister_hold"}, 32'(wr),
          32'(vecs[i].e_wr));
    end

    // Full/starve: wb held 5 cycles, MDU offers r8, r9, r10.
    idle_in();
    for (int c = 0; c < 5; c++) begin
      wb_valid  = 1;
      wb_addr   = 5'(20 + c);
      wb_data   = 32'(c);
      mdu_valid = 1;
      mdu_addr  = (c == 0) ? 5'd8 : (c == 1) ? 5'd9 : 5'd10;
      mdu_data  = {27'd0, mdu_addr} << 4;
      tick();
      chk_out($sformatf("starve%0d", c), 1, 5'(20 + c), 32'(c),
              c == 0, c != 0);
    end
    wb_valid = 0;
    wb_addr  = 0;
    tick();
    chk_out("drain_r8", 1, 8, 32'h80, 1, 0);
    tick();
    chk_out("drain_r9", 1, 9, 32'h90, 1, 0);
    mdu_valid = 0;
    tick();
    chk_out("drain_r10", 1, 10, 32'hA0, 1, 0);
    tick();
    chk_out("drain_done", 0, 0, 0, 1, 0);

    // Mid-operation start flushes buffer and in-flight write.
    wb_valid = 1; wb_addr = 2; wb_data = 32'h2;
    mdu_valid = 1; mdu_addr = 14; mdu_data = 32'hE;
    tick();
    mdu_addr = 15; mdu_data = 32'hF;
    tick();
    chk("flush_pre.stall", 32'(stall), 1);
    idle_in();
    start = 1;
    tick();
    start = 0;
    chk("flush.RegWrite", 32'(rw), 0);
    chk("flush.WriteRegister", 32'(wr), 0);
    chk("flush.mdu_ready", 32'(mdu_ready), 1);
    chk("flush.stall", 32'(stall), 0);
    tick();
    chk("flush_empty.RegWrite", 32'(rw), 0);
    tick();
    chk("flush_empty2.RegWrite", 32'(rw), 0);

`ifdef WB_SCOREBOARD_EN
    // RAW on r9 stalls until its MDU result reaches the write port.
    mdu_issue = 1; mdu_issue_addr = 9;
    tick();
    mdu_issue = 0; mdu_issue_addr = 0;
    rr1 = 9;
    #1;
    chk("sb_raw.stall", 32'(stall), 1);
    rr1 = 0; rr2 = 9;
    #1;
    chk("sb_raw2.stall", 32'(stall), 1);
    rr2 = 0; mdu_issue = 1; mdu_issue_addr = 9;
    #1;
    chk("sb_waw.stall", 32'(stall), 1);
    mdu_issue = 0; mdu_issue_addr = 0; rr1 = 9;
    tick();
    chk("sb_wait.stall", 32'(stall), 1);
    mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h99;
    tick();
    mdu_valid = 0; mdu_addr = 0;
    chk("sb_buf.RegWrite", 32'(rw), 0);
    chk("sb_buf.stall", 32'(stall), 1);
    tick();
    chk("sb_wr.RegWrite", 32'(rw), 1);
    chk("sb_wr.WriteRegister", 32'(wr), 9);
    chk("sb_wr.stall", 32'(stall), 0);
    rr1 = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
